// File: rtl/spi_burst_ctrl_pkg.sv
// Shared types for the SPI burst sequencer.
// Sequencer state encoding and bit-counter sizing.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        STORE
    } state_t;

    localparam int DATA_W_DEF = 8;
    localparam int BIT_CNT_W  = $clog2(DATA_W_DEF + 1);

    function automatic int bit_cnt_w(input int dw);
        return $clog2(dw + 1);
    endfunction

endpackage

// File: rtl/spi_burst_ctrl_if.sv
// FIFO/register-side signal bundle of the SPI burst sequencer.
// The slave modport is the sequencer's view.
interface spi_burst_ctrl_if #(
    parameter int BURST_W = 4,
    parameter int DIV_W   = 8
);
    logic               spe;
    logic [BURST_W-1:0] burst_len;
    logic [DIV_W-1:0]   clk_div;
    logic               w_fifo_empty;
    logic               r_fifo_full;
    logic               spif_clr;
    logic               w_fifo_en;
    logic               r_fifo_en;
    logic               spi_transfer_en;
    logic               bit_tick;
    logic               busy;
    logic               spif;
    logic               underrun;
    logic [BURST_W-1:0] word_cnt;

    modport slave (
        input  spe, burst_len, clk_div,
        input  w_fifo_empty, r_fifo_full, spif_clr,
        output w_fifo_en, r_fifo_en, spi_transfer_en,
        output bit_tick, busy, spif, underrun, word_cnt
    );

    modport master (
        output spe, burst_len, clk_div,
        output w_fifo_empty, r_fifo_full, spif_clr,
        input  w_fifo_en, r_fifo_en, spi_transfer_en,
        input  bit_tick, busy, spif, underrun, word_cnt
    );
endinterface

// File: rtl/spi_burst_ctrl_bit_timer.sv
// Bit-period divider and bit counter for one SPI word.
// last_bit marks the tick that completes the DATA_W-th bit.
module spi_bit_timer
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             run,
    input  logic [DIV_W-1:0] clk_div_q,
    output logic             bit_tick,
    output logic             last_bit
);
    localparam int BCW = bit_cnt_w(DATA_W);

    logic [DIV_W-1:0] r_div_cnt;
    logic [BCW-1:0]   r_bit_cnt;
    logic             w_wrap;

    assign w_wrap   = (r_div_cnt == clk_div_q);
    assign bit_tick = run && w_wrap;
    assign last_bit = bit_tick && (r_bit_cnt == BCW'(DATA_W - 1));

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
        end else if (run) begin
            if (w_wrap) begin
                r_div_cnt <= '0;
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/spi_burst_ctrl.sv
// SPI burst sequencer: pops TX words, paces the shift window,
// pushes RX words and reports sticky completion/underrun.
module spi_burst_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int BURST_W = 4,
    parameter int DIV_W   = 8
) (
    input logic               clk,
    input logic               reset,
    spi_burst_ctrl_if.slave   ctrl
);
    state_t             r_state;
    state_t             w_state_n;
    logic [BURST_W-1:0] r_word_cnt;
    logic [BURST_W-1:0] r_burst_len_q;
    logic [DIV_W-1:0]   r_clk_div_q;
    logic               r_spif;
    logic               r_underrun;

    logic w_pop;
    logic w_push;
    logic w_set_spif;
    logic w_set_ur;
    logic w_inc;
    logic w_latch;
    logic w_run;
    logic w_tick;
    logic w_last_bit;

    assign w_run = ctrl.spe && (r_state == SHIFT);

    spi_bit_timer #(
        .DATA_W (DATA_W),
        .DIV_W  (DIV_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clr       (r_state != SHIFT),
        .run       (w_run),
        .clk_div_q (r_clk_div_q),
        .bit_tick  (w_tick),
        .last_bit  (w_last_bit)
    );

    always_comb begin
        w_state_n  = r_state;
        w_pop      = 1'b0;
        w_push     = 1'b0;
        w_set_spif = 1'b0;
        w_set_ur   = 1'b0;
        w_inc      = 1'b0;
        w_latch    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (ctrl.spe && !ctrl.w_fifo_empty) begin
                    w_state_n = LOAD;
                    w_latch   = 1'b1;
                end
            end
            LOAD: begin
                w_pop     = 1'b1;
                w_state_n = SHIFT;
            end
            SHIFT: begin
                if (w_last_bit) w_state_n = STORE;
            end
            STORE: begin
                // A full RX FIFO stalls here with no strobes.
                if (!ctrl.r_fifo_full) begin
                    w_push = 1'b1;
                    if (r_word_cnt == r_burst_len_q) begin
                        w_set_spif = 1'b1;
                        w_state_n  = IDLE;
                    end else if (ctrl.w_fifo_empty) begin
                        w_set_spif = 1'b1;
                        w_set_ur   = 1'b1;
                        w_state_n  = IDLE;
                    end else begin
                        w_pop     = 1'b1;
                        w_inc     = 1'b1;
                        w_state_n = SHIFT;
                    end
                end
            end
            default: w_state_n = IDLE;
        endcase
        // Disabling aborts immediately and drops the partial word.
        if (!ctrl.spe) begin
            w_state_n  = IDLE;
            w_pop      = 1'b0;
            w_push     = 1'b0;
            w_set_spif = 1'b0;
            w_set_ur   = 1'b0;
            w_inc      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_word_cnt    <= '0;
            r_burst_len_q <= '0;
            r_clk_div_q   <= '0;
            r_spif        <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_state <= w_state_n;
            if (w_latch) begin
                r_burst_len_q <= ctrl.burst_len;
                r_clk_div_q   <= ctrl.clk_div;
                r_word_cnt    <= '0;
            end else if (w_inc) begin
                r_word_cnt <= r_word_cnt + 1'b1;
            end
            if (w_set_spif)         r_spif <= 1'b1;
            else if (ctrl.spif_clr) r_spif <= 1'b0;
            if (w_set_ur)           r_underrun <= 1'b1;
            else if (ctrl.spif_clr) r_underrun <= 1'b0;
        end
    end

    assign ctrl.w_fifo_en       = w_pop;
    assign ctrl.r_fifo_en       = w_push;
    assign ctrl.spi_transfer_en = w_run;
    assign ctrl.bit_tick        = w_tick;
    assign ctrl.busy            = (r_state != IDLE);
    assign ctrl.spif            = r_spif;
    assign ctrl.underrun        = r_underrun;
    assign ctrl.word_cnt        = r_word_cnt;
endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Scoreboard bench for spi_burst_ctrl: stimulus queues expected
// per-word and per-burst results, a negedge monitor checks them.
module tb_spi_burst_ctrl;
    localparam int DW = 8;
    localparam int BW = 4;
    localparam int VW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_burst_ctrl_if #(.BURST_W(BW), .DIV_W(VW)) bus ();

    spi_burst_ctrl #(
        .DATA_W  (DW),
        .BURST_W (BW),
        .DIV_W   (VW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ctrl  (bus)
    );

    typedef struct {
        int pops;
        int pushes;
        int ticks;
        bit spif;
        bit ur;
        int dur;
        int div;
    } burst_t;

    burst_t sb_sum[$];
    int     sb_word[$];

    int checks   = 0;
    int failures = 0;
    int pushed   = 0;
    int popped   = 0;
    int tick_total = 0;
    bit mspif = 0;
    bit mur   = 0;

    // TX FIFO model: words written by stimulus, popped by DUT
    assign bus.w_fifo_empty = (pushed == popped);
    always @(posedge clk) if (bus.w_fifo_en) popped <= popped + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    int  cyc = 0;
    int  m_pops, m_pushes, m_ticks, m_busy, m_wticks, m_last;
    bit  prev_busy = 0;
    burst_t e;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            m_pops = 0; m_pushes = 0; m_ticks = 0;
            m_busy = 0; m_wticks = 0; prev_busy = 0;
        end else begin
            if (bus.r_fifo_full) check("push_while_full", bus.r_fifo_en, 0);
            if (bus.bit_tick) begin
                if (m_wticks > 0 && sb_sum.size() > 0)
                    check("tick_gap", cyc - m_last, sb_sum[0].div + 1);
                m_last = cyc;
                m_wticks++;
                m_ticks++;
                tick_total++;
            end
            if (bus.r_fifo_en) begin
                m_pushes++;
                check("bits_per_word", m_wticks, DW);
                if (sb_word.size() == 0) fail("unexpected_push");
                else check("word_cnt", bus.word_cnt, sb_word.pop_front());
            end
            if (bus.w_fifo_en) begin
                check("pop_while_empty", bus.w_fifo_empty, 0);
                m_pops++;
                m_wticks = 0;
            end
            if (bus.busy) m_busy++;
            if (prev_busy && !bus.busy) begin
                if (sb_sum.size() == 0) begin
                    fail("unexpected_burst_end");
                end else begin
                    e = sb_sum.pop_front();
                    check("burst_pops", m_pops, e.pops);
                    check("burst_pushes", m_pushes, e.pushes);
                    check("burst_ticks", m_ticks, e.ticks);
                    check("burst_spif", bus.spif, e.spif);
                    check("burst_underrun", bus.underrun, e.ur);
                    check("burst_cycles", m_busy, e.dur);
                end
                m_pops = 0; m_pushes = 0; m_ticks = 0;
                m_busy = 0; m_wticks = 0;
            end
            prev_busy = bus.busy;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 3000) begin
            step();
            n++;
        end
        if (bus.busy) fail("timeout_idle");
    endtask

    task automatic wait_ticks(input int target);
        int n = 0;
        while (tick_total < target && n < 3000) begin
            step();
            n++;
        end
        if (tick_total < target) fail("timeout_ticks");
    endtask

    task automatic pre_clear();
        bus.spif_clr = 1'b1;
        step();
        bus.spif_clr = 1'b0;
        mspif = 0;
        mur   = 0;
    endtask

    task automatic burst(input int bl, input int div, input int words,
                         input int stall, input bit clr_during);
        burst_t r;
        int n, base;
        pre_clear();
        n = (words < bl + 1) ? words : bl + 1;
        r.pops   = n;
        r.pushes = n;
        r.ticks  = n * DW;
        r.spif   = 1;
        r.ur     = (words < bl + 1);
        r.dur    = 1 + n * (DW * (div + 1) + 1) + stall;
        r.div    = div;
        sb_sum.push_back(r);
        for (int i = 0; i < n; i++) sb_word.push_back(i);
        mspif = 1;
        mur   = r.ur;
        bus.burst_len = BW'(bl);
        bus.clk_div   = VW'(div);
        base = tick_total;
        if (clr_during) bus.spif_clr = 1'b1;
        pushed += words;
        step();
        step();
        // Latched values must ignore these mid-burst changes.
        bus.burst_len = BW'($urandom);
        bus.clk_div   = VW'($urandom);
        if (stall > 0) begin
            bus.r_fifo_full = 1'b1;
            wait_ticks(base + DW);
            repeat (stall) @(posedge clk);
            #1;
            bus.r_fifo_full = 1'b0;
        end
        wait_idle();
        if (clr_during) begin
            step();
            bus.spif_clr = 1'b0;
            @(negedge clk);
            check("clr_spif", bus.spif, 0);
            check("clr_underrun", bus.underrun, 0);
            mspif = 0;
            mur   = 0;
            step();
        end
    endtask

    task automatic abort_burst(input int div);
        burst_t r;
        int base;
        r.pops   = 1;
        r.pushes = 0;
        r.ticks  = 4;
        r.spif   = mspif;
        r.ur     = mur;
        r.dur    = 4 * (div + 1) + 2;
        r.div    = div;
        sb_sum.push_back(r);
        bus.burst_len = BW'(3);
        bus.clk_div   = VW'(div);
        base = tick_total;
        pushed += 1;
        step();
        step();
        wait_ticks(base + 4);
        bus.spe = 1'b0;
        @(negedge clk);
        check("abort_xfer_en", bus.spi_transfer_en, 0);
        check("abort_tick", bus.bit_tick, 0);
        check("abort_pop", bus.w_fifo_en, 0);
        @(negedge clk);
        check("abort_busy", bus.busy, 0);
        check("abort_spif", bus.spif, mspif);
        step();
        bus.spe = 1'b1;
        step();
    endtask

    initial begin
        int bl, div, words, base;
        reset = 1'b1;
        bus.spe = 1'b0;
        bus.burst_len = '0;
        bus.clk_div = '0;
        bus.r_fifo_full = 1'b0;
        bus.spif_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs",
              int'({bus.busy, bus.spif, bus.underrun, bus.w_fifo_en,
                    bus.r_fifo_en, bus.spi_transfer_en, bus.bit_tick,
                    bus.word_cnt}), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.spe = 1'b1;
        step();

        burst(0, 0, 1, 0, 0);
        burst(3, 3, 4, 0, 0);
        burst(3, 1, 2, 0, 0);
        burst(2, 1, 3, 10, 0);
        burst(3, 0, 2, 0, 1);
        burst(15, 0, 16, 0, 0);

        for (int k = 0; k < 6; k++) begin
            bl  = $urandom_range(0, 15);
            div = $urandom_range(0, 3);
            words = ($urandom_range(0, 3) == 0) ?
                    $urandom_range(1, bl + 1) : bl + 1;
            burst(bl, div, words, ($urandom_range(0, 2) == 0) ? 3 : 0, 0);
        end

        abort_burst(1);
        burst(1, 0, 2, 0, 0);

        // Reset mid-burst while spif is still set.
        bus.burst_len = '0;
        bus.clk_div = VW'(1);
        base = tick_total;
        pushed += 1;
        step();
        step();
        wait_ticks(base + 3);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midburst_rst",
              int'({bus.busy, bus.spif, bus.underrun, bus.w_fifo_en,
                    bus.r_fifo_en, bus.spi_transfer_en, bus.bit_tick,
                    bus.word_cnt}), 0);
        step();
        reset = 1'b0;
        step();

        check("sb_sum_left", sb_sum.size(), 0);
        check("sb_word_left", sb_word.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
